// File: rtl/pwmfeeder.sv
// pwmfeeder: buffers stream samples in a FIFO and writes one to the PWM controller's data register per
// need-sample interrupt, substituting silence and counting underruns when the FIFO is empty.
module pwmfeeder #(
    parameter int          LGFIFO  = 5,
    parameter int          NAUX    = 2,
    parameter int          TIMEOUT = 15,
    parameter logic [15:0] SILENCE = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [15:0]       i_sample,
    input  logic [NAUX-1:0]   i_aux,
    input  logic              i_pwm_int,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic              o_wb_addr,
    output logic [31:0]       o_wb_data,
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    output logic [LGFIFO:0]   o_fill,
    output logic [15:0]       o_underruns,
    output logic              o_timeout
);
    localparam int             DEPTH = 2 ** LGFIFO;
    localparam int             EW    = NAUX + 17;
    localparam logic [LGFIFO:0] FULL = (LGFIFO + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, HOLD} state_t;

    state_t              state, state_next;
    logic [EW-1:0]       mem [DEPTH];
    logic [LGFIFO-1:0]   wr_ptr, rd_ptr;
    logic                push, pop, launch, empty;
    logic                cyc_next, stb_next, timeout_next;
    logic [31:0]         data_next;
    logic [15:0]         underruns_next;
    logic [3:0]          cnt, cnt_next;

    // FIFO entry {aux, 1, sample} maps to the controller word with the aux-set flag at bit 16
    function automatic logic [31:0] pack(input logic [EW-1:0] e);
        logic [31:0] w;
        w = '0;
        w[16:0] = e[16:0];
        w[20 +: NAUX] = e[EW-1 -: NAUX];
        return w;
    endfunction

    assign o_ready   = o_fill != FULL;
    assign o_wb_addr = 1'b0;
    assign empty     = o_fill == '0;
    assign launch    = state == IDLE && i_enable && i_pwm_int;
    assign push      = i_valid && o_ready;
    assign pop       = launch && !empty;

    always_ff @(posedge i_clk)
        if (push)
            mem[wr_ptr] <= {i_aux, 1'b1, i_sample};

    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_fill <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            o_fill <= o_fill + {{LGFIFO{1'b0}}, push} - {{LGFIFO{1'b0}}, pop};
        end

    always_comb begin
        state_next     = state;
        cyc_next       = o_wb_cyc;
        stb_next       = o_wb_stb;
        data_next      = o_wb_data;
        underruns_next = o_underruns;
        timeout_next   = 1'b0;
        cnt_next       = cnt;
        case (state)
            IDLE:
                if (launch) begin
                    data_next      = empty ? 32'(SILENCE) : pack(mem[rd_ptr]);
                    underruns_next = (empty && o_underruns != 16'hFFFF) ? o_underruns + 16'd1 : o_underruns;
                    cyc_next       = 1'b1;
                    stb_next       = 1'b1;
                    state_next     = STROBE;
                end
            STROBE:
                if (!i_wb_stall) begin
                    stb_next   = 1'b0;
                    cyc_next   = !i_wb_ack;
                    cnt_next   = '0;
                    state_next = i_wb_ack ? HOLD : WAIT;
                end
            WAIT:
                if (i_wb_ack || cnt == 4'(TIMEOUT - 1)) begin
                    cyc_next     = 1'b0;
                    timeout_next = !i_wb_ack;
                    state_next   = HOLD;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            default:
                state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            state       <= IDLE;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_data   <= '0;
            o_underruns <= '0;
            o_timeout   <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_next;
            o_wb_cyc    <= cyc_next;
            o_wb_stb    <= stb_next;
            o_wb_we     <= stb_next;
            o_wb_data   <= data_next;
            o_underruns <= underruns_next;
            o_timeout   <= timeout_next;
            cnt         <= cnt_next;
        end
endmodule
